spi_segment_mux: RTL

Parametrised SPI-driven multi-digit 7-segment display controller. It receives 16-bit command frames from an external SPI master, stores per-digit segment patterns, and time-multiplexes them onto a shared segment bus with per-digit enables and 16-level PWM brightness. It sits between the chip-level pin wrapper (SPI on dedicated inputs, segments/digit enables on outputs) and the display.

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/spi_frame_rx.sv | 86 ++++++++
 rtl/spi_segment_mux.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the SPI 7-segment display controller: command codes, frame layout, hex decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seg_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] CMD_WRITE_RAW = 4'h1;
  localparam logic [3:0] CMD_WRITE_HEX = 4'h2;
  localparam logic [3:0] CMD_BRIGHT    = 4'h3;
  localparam logic [3:0] CMD_ENABLE    = 4'h4;

  // Command frame as shifted in MSB first.
  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  // Hex digit to {g,f,e,d,c,b,a}, active-high segments; b and d are lower case.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises SCK/CS/MOSI into clk and collects one 16-bit frame per CS window.
// Latency: frame_valid/frame_bad pulse 1 cycle after the synchronised CS rising edge is seen (~3 clk after the pin).
// Backpressure: none; the master cannot be stalled, so every CS window yields exactly one valid or bad pulse.
module spi_frame_rx
  import seg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sck,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_bad
);

  // [0],[1] form the synchroniser; [2] is the previous synchronised value for edge detection.
  logic [2:0]         sck_q, sck_d;
  logic [2:0]         cs_q, cs_d;
  logic [1:0]         mosi_q, mosi_d;
  logic               active_q, active_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [4:0]         bits_q, bits_d;
  logic               valid_q, valid_d;
  logic               bad_q, bad_d;
  logic               sck_rise, cs_fall, cs_rise;

  // Edge detection, shifting, and frame accept/reject at CS release.
  always_comb begin
    sck_d    = {sck_q[1:0], spi_sck};
    cs_d     = {cs_q[1:0], spi_cs_n};
    mosi_d   = {mosi_q[0], spi_mosi};
    active_d = active_q;
    shift_d  = shift_q;
    bits_d   = bits_q;
    valid_d  = 1'b0;
    bad_d    = 1'b0;
    sck_rise = sck_q[1] & ~sck_q[2];
    cs_fall  = ~cs_q[1] & cs_q[2];
    cs_rise  = cs_q[1] & ~cs_q[2];
    if (cs_fall) begin
      active_d = 1'b1;
      shift_d  = '0;
      bits_d   = '0;
    end else if (active_q) begin
      if (cs_rise) begin
        active_d = 1'b0;
        valid_d  = (bits_q == 5'd16);
        bad_d    = (bits_q != 5'd16);
      end else if (sck_rise) begin
        // MOSI goes through the same sync depth as SCK, so mosi_q[1] is the bit launched with this edge.
        shift_d = {shift_q[FRAME_W-2:0], mosi_q[1]};
        if (bits_q != 5'd17) bits_d = bits_q + 5'd1;
      end
    end
  end

  // CS sync resets low so a CS held low across reset never looks like a falling edge;
  // the receiver stays idle until a genuine new CS falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      active_q <= 1'b0;
      shift_q  <= '0;
      bits_q   <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      active_q <= active_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame       = shift_q;
  assign frame_bad   = bad_q;

endmodule

// File: rtl/spi_segment_mux.sv
// SPI-programmed multiplexed 7-segment driver with 16-level PWM brightness and per-digit enables.
// Latency: register update 1 cycle after rx frame pulse; seg/dig_en are registered (1 cycle from scan state).
// Backpressure: none; rejected frames (bad length, unknown cmd, bad addr) only raise a frame_err pulse.
module spi_segment_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PWM_STEP       = 625,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_err
);

  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP_W = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic               rx_frame_vld;
  logic               rx_frame_bad;
  logic [FRAME_W-1:0] rx_frame_dat;
  frame_t             f;
  logic               addr_ok;
  logic               cmd_err;

  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  logic [3:0]            bright_q, bright_d;
  logic                  en_q, en_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [3:0]            phase_q, phase_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  err_q, err_d;
  logic [7:0]            cur_seg;

  spi_frame_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .frame_valid (rx_frame_vld),
    .frame       (rx_frame_dat),
    .frame_bad   (rx_frame_bad)
  );

  assign f       = rx_frame_dat;
  assign addr_ok = ({1'b0, f.addr} < 5'(NUM_DIGITS));

  // Command decode: apply an accepted frame to the digit file / brightness / enable.
  always_comb begin
    digit_d  = digit_q;
    bright_d = bright_q;
    en_d     = en_q;
    cmd_err  = 1'b0;
    if (rx_frame_vld) begin
      case (f.cmd)
        CMD_WRITE_RAW, CMD_WRITE_HEX: begin
          if (addr_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (f.addr == 4'(i)) begin
                digit_d[i] = (f.cmd == CMD_WRITE_HEX) ? {f.data[7], hex_to_seg(f.data[3:0])} : f.data;
              end
            end
          end else begin
            cmd_err = 1'b1;
          end
        end
        CMD_BRIGHT: bright_d = f.data[3:0];
        CMD_ENABLE: en_d     = f.data[0];
        default:    cmd_err  = 1'b1;
      endcase
    end
    err_d = rx_frame_bad | cmd_err;
  end

  // Scan timing: PWM_STEP cycles per phase, 16 phases per digit slot; the last cycle of
  // phase 15 moves to the next digit and phase 0 together so slots abut exactly.
  always_comb begin
    phase_d = phase_q;
    scan_d  = scan_q;
    if (step_q == STEP_W'(PWM_STEP - 1)) begin
      step_d  = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        scan_d = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      end
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  // Output mapping: select the scanned digit, gate it by enable and brightness, apply polarity.
  always_comb begin
    cur_seg = 8'h00;
    dig_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        cur_seg  = digit_q[i];
        dig_d[i] = 1'b1;
      end
    end
    seg_d = ((en_q && (phase_q <= bright_q)) ? cur_seg : 8'h00) ^ SEG_OFF;
    dig_d = dig_d ^ DIG_OFF;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 8'h00;
      bright_q <= 4'hF;
      en_q     <= 1'b1;
      step_q   <= '0;
      phase_q  <= '0;
      scan_q   <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      err_q    <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      bright_q <= bright_d;
      en_q     <= en_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      scan_q   <= scan_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      err_q    <= err_d;
    end
  end

  assign seg       = seg_q;
  assign dig_en    = dig_q;
  assign frame_err = err_q;

endmodule
